// File: rtl/mem_pkg.sv
// Shared LSU definitions: funct3 access encodings and FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    IDLE,
    BUSY
  } lsu_state_t;

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension.
module load_extend
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OW   = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] data,
  input  logic [OW-1:0]   off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [XLEN-1:0] s;

  always_comb begin
    s   = data >> {off, 3'b000};
    ext = s;
    unique case (1'b1)
      funct3 == F3_B:  ext = XLEN'($signed(s[7:0]));
      funct3 == F3_H:  ext = XLEN'($signed(s[15:0]));
      funct3 == F3_W:  ext = XLEN'($signed(s[31:0]));
      funct3 == F3_BU: ext = XLEN'(s[7:0]);
      funct3 == F3_HU: ext = XLEN'(s[15:0]);
      funct3 == F3_WU: ext = XLEN'(s[31:0]);
      default:         ext = s;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with load/store unit and variable-latency
// data memory handshake.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXE_rdsrc,
  input  logic              EXE_MemRead,
  input  logic              EXE_MemWrite,
  input  logic              EXE_MemtoReg,
  input  logic              EXE_RegWrite,
  input  logic [XLEN-1:0]   EXE_ALUout,
  input  logic [XLEN-1:0]   EXE_PCtoReg,
  input  logic [XLEN-1:0]   EXE_rs2data,
  input  logic [4:0]        EXE_rdaddr,
  input  logic [2:0]        EXE_Funct3,
  output logic [XLEN-1:0]   Forward_Memrddata,
  output logic              MEM_stall,
  output logic              MEM_misalign,
  output logic [XLEN-1:0]   MEM_rddata,
  output logic [XLEN-1:0]   MEM_dout,
  output logic [4:0]        MEM_rdaddr,
  output logic              MEM_MemtoReg,
  output logic              MEM_RegWrite,
  output logic              DM_req,
  output logic [XLEN/8-1:0] DM_WEB,
  output logic [AW-1:0]     DM_addr,
  output logic [XLEN-1:0]   DM_din,
  input  logic [XLEN-1:0]   DM_dataout,
  input  logic              DM_ready
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  lsu_state_t      state;
  logic [OW-1:0]   off, lat_off, off_cur, amask;
  logic [2:0]      lat_f3, f3_cur;
  logic [AW-1:0]   ea, lat_addr;
  logic [NB-1:0]   bmask, web_new, lat_web;
  logic [XLEN-1:0] din_new, lat_din, ld_ext;
  logic            mem_op, mis_raw, mis, go, busy;
  logic            lat_rd, rd_cur, done;

  assign busy    = (state == BUSY);
  assign off     = EXE_ALUout[OW-1:0];
  assign mem_op  = EXE_MemRead | EXE_MemWrite;
  assign amask   = OW'((4'd1 << EXE_Funct3[1:0]) - 4'd1);
  assign mis_raw = |(off & amask);
  assign mis     = ~busy & mem_op & mis_raw;
  assign go      = ~rst & ~busy & mem_op & ~mis_raw;

  // Byte lanes touched: 2^size ones starting at off
  assign bmask   = NB'((16'd1 << (4'd1 << EXE_Funct3[1:0])) - 16'd1) << off;
  assign web_new = EXE_MemWrite ? ~bmask : '1;
  assign din_new = EXE_rs2data << {off, 3'b000};
  assign ea      = AW'(EXE_ALUout) & ~AW'(NB - 1);

  assign DM_req  = go | (~rst & busy);
  assign DM_addr = busy ? lat_addr : ea;
  assign DM_din  = busy ? lat_din : din_new;
  assign DM_WEB  = ~DM_req ? '1 : (busy ? lat_web : web_new);

  assign done      = DM_req & DM_ready;
  assign MEM_stall = DM_req & ~DM_ready;

  assign rd_cur  = busy ? lat_rd : EXE_MemRead;
  assign off_cur = busy ? lat_off : off;
  assign f3_cur  = busy ? lat_f3 : EXE_Funct3;

  assign Forward_Memrddata = EXE_rdsrc ? EXE_PCtoReg : EXE_ALUout;

  load_extend #(.XLEN(XLEN), .OW(OW)) u_ext (
    .data   (DM_dataout),
    .off    (off_cur),
    .funct3 (f3_cur),
    .ext    (ld_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_web      <= '1;
      lat_din      <= '0;
      lat_off      <= '0;
      lat_f3       <= '0;
      lat_rd       <= 1'b0;
      MEM_misalign <= 1'b0;
      MEM_rddata   <= '0;
      MEM_dout     <= '0;
      MEM_rdaddr   <= '0;
      MEM_MemtoReg <= 1'b0;
      MEM_RegWrite <= 1'b0;
    end else begin
      MEM_misalign <= 1'b0;
      unique case (state)
        IDLE: if (go && !DM_ready) begin
          state    <= BUSY;
          lat_addr <= ea;
          lat_web  <= web_new;
          lat_din  <= din_new;
          lat_off  <= off;
          lat_f3   <= EXE_Funct3;
          lat_rd   <= EXE_MemRead;
        end
        BUSY: if (DM_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!MEM_stall) begin
        MEM_rddata   <= Forward_Memrddata;
        MEM_rdaddr   <= EXE_rdaddr;
        MEM_MemtoReg <= EXE_MemtoReg;
        MEM_RegWrite <= EXE_RegWrite & ~mis;
        MEM_misalign <= mis;
      end
      if (done && rd_cur) MEM_dout <= ld_ext;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu at XLEN=32 and XLEN=64.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic rdsrc, mr, mw, m2r, rw, rdy;
  logic [31:0] alu, pc, rs2, dmo;
  logic [4:0] rda;
  logic [2:0] f3;
  logic [31:0] fwd, rdd, dout, addr, din;
  logic stall, mis, m_m2r, m_rw, req;
  logic [4:0] m_rda;
  logic [3:0] web;

  logic w_mr, w_mw, w_rdy;
  logic [63:0] w_alu, w_rs2, w_dmo;
  logic [2:0] w_f3;
  logic [63:0] w_fwd, w_rdd, w_dout, w_din;
  logic [31:0] w_addr;
  logic w_stall, w_mis, w_m2r, w_rw, w_req;
  logic [4:0] w_rda;
  logic [7:0] w_web;

  mem_stage_lsu #(.XLEN(32), .AW(32)) u32 (
    .clk(clk), .rst(rst),
    .EXE_rdsrc(rdsrc), .EXE_MemRead(mr),
    .EXE_MemWrite(mw), .EXE_MemtoReg(m2r),
    .EXE_RegWrite(rw), .EXE_ALUout(alu),
    .EXE_PCtoReg(pc), .EXE_rs2data(rs2),
    .EXE_rdaddr(rda), .EXE_Funct3(f3),
    .Forward_Memrddata(fwd), .MEM_stall(stall),
    .MEM_misalign(mis), .MEM_rddata(rdd),
    .MEM_dout(dout), .MEM_rdaddr(m_rda),
    .MEM_MemtoReg(m_m2r), .MEM_RegWrite(m_rw),
    .DM_req(req), .DM_WEB(web), .DM_addr(addr),
    .DM_din(din), .DM_dataout(dmo), .DM_ready(rdy)
  );

  mem_stage_lsu #(.XLEN(64), .AW(32)) u64 (
    .clk(clk), .rst(rst),
    .EXE_rdsrc(1'b0), .EXE_MemRead(w_mr),
    .EXE_MemWrite(w_mw), .EXE_MemtoReg(w_mr),
    .EXE_RegWrite(w_mr), .EXE_ALUout(w_alu),
    .EXE_PCtoReg(64'd0), .EXE_rs2data(w_rs2),
    .EXE_rdaddr(5'd9), .EXE_Funct3(w_f3),
    .Forward_Memrddata(w_fwd), .MEM_stall(w_stall),
    .MEM_misalign(w_mis), .MEM_rddata(w_rdd),
    .MEM_dout(w_dout), .MEM_rdaddr(w_rda),
    .MEM_MemtoReg(w_m2r), .MEM_RegWrite(w_rw),
    .DM_req(w_req), .DM_WEB(w_web), .DM_addr(w_addr),
    .DM_din(w_din), .DM_dataout(w_dmo), .DM_ready(w_rdy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rdsrc = 0; mr = 0; mw = 0; m2r = 0; rw = 0;
    alu = 0; pc = 0; rs2 = 0; rda = 0; f3 = 0;
    dmo = 0; rdy = 0;
    w_mr = 0; w_mw = 0; w_rdy = 0;
    w_alu = 0; w_rs2 = 0; w_dmo = 0; w_f3 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clr();
    step();
    step();
    rst = 0;
    #2;
    total++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL rst_req got %b exp 0", req);
    end
    total++;
    if (web !== 4'hF) begin
      bad++; $display("FAIL rst_web got %h exp f", web);
    end
    total++;
    if ({rdd, dout, m_rda, m_m2r, m_rw, mis} !== '0) begin
      bad++;
      $display("FAIL rst_regs got %h %h %h %b %b %b exp 0",
               rdd, dout, m_rda, m_m2r, m_rw, mis);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL rst_stall got %b exp 0", stall);
    end
    step();
  endtask

  task automatic test_store(input string nm, input logic [2:0] f,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] ew, input logic [31:0] ed);
    mw = 1; f3 = f; alu = a; rs2 = d; rdy = 1;
    #2;
    total++;
    if (req !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL %s_req got %b/%b exp 1/0", nm, req, stall);
    end
    total++;
    if (web !== ew) begin
      bad++; $display("FAIL %s_web got %h exp %h", nm, web, ew);
    end
    total++;
    if (din !== ed) begin
      bad++; $display("FAIL %s_din got %h exp %h", nm, din, ed);
    end
    total++;
    if (addr !== (a & 32'hFFFF_FFFC)) begin
      bad++; $display("FAIL %s_addr got %h exp %h", nm, addr, a & 32'hFFFF_FFFC);
    end
    step();
    clr();
  endtask

  task automatic test_load(input string nm, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d,
                           input int waits, input logic [31:0] exp);
    mr = 1; m2r = 1; rw = 1; rda = 5'd7;
    f3 = f; alu = a; dmo = d; rdy = 0;
    for (int i = 0; i < waits; i++) begin
      #2;
      total++;
      if (stall !== 1'b1 || req !== 1'b1) begin
        bad++; $display("FAIL %s_wait%0d got stall=%b req=%b exp 1/1", nm, i, stall, req);
      end
      total++;
      if (addr !== (a & 32'hFFFF_FFFC) || web !== 4'hF) begin
        bad++; $display("FAIL %s_hold%0d got %h/%h exp %h/f", nm, i, addr, web, a & 32'hFFFF_FFFC);
      end
      step();
    end
    rdy = 1;
    #2;
    total++;
    if (stall !== 1'b0 || req !== 1'b1) begin
      bad++; $display("FAIL %s_done got stall=%b req=%b exp 0/1", nm, stall, req);
    end
    step();
    clr();
    total++;
    if (dout !== exp) begin
      bad++; $display("FAIL %s_dout got %h exp %h", nm, dout, exp);
    end
    total++;
    if (m_rda !== 5'd7 || m_rw !== 1'b1 || m_m2r !== 1'b1) begin
      bad++; $display("FAIL %s_pipe got %0d %b %b exp 7 1 1", nm, m_rda, m_rw, m_m2r);
    end
  endtask

  task automatic test_misalign(input string nm, input logic [2:0] f,
                               input logic [31:0] a, input logic st);
    mr = ~st; mw = st; rw = ~st; m2r = ~st;
    f3 = f; alu = a; rs2 = 32'hFFFF_FFFF;
    #2;
    total++;
    if (req !== 1'b0 || stall !== 1'b0 || web !== 4'hF) begin
      bad++; $display("FAIL %s_noreq got %b %b %h exp 0 0 f", nm, req, stall, web);
    end
    step();
    clr();
    total++;
    if (mis !== 1'b1 || m_rw !== 1'b0) begin
      bad++; $display("FAIL %s_flag got mis=%b rw=%b exp 1 0", nm, mis, m_rw);
    end
    step();
    total++;
    if (mis !== 1'b0) begin
      bad++; $display("FAIL %s_pulse got %b exp 0", nm, mis);
    end
  endtask

  task automatic test_jal();
    logic [31:0] prev;
    prev = dout;
    rdsrc = 1; pc = 32'h204; alu = 32'h999; rw = 1; rda = 5'd1;
    #2;
    total++;
    if (fwd !== 32'h204) begin
      bad++; $display("FAIL jal_fwd got %h exp 204", fwd);
    end
    total++;
    if (req !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL jal_req got %b/%b exp 0/0", req, stall);
    end
    step();
    rdsrc = 0;
    #2;
    total++;
    if (fwd !== 32'h999) begin
      bad++; $display("FAIL alu_fwd got %h exp 999", fwd);
    end
    total++;
    if (rdd !== 32'h204 || m_rw !== 1'b1 || m_rda !== 5'd1) begin
      bad++; $display("FAIL jal_pipe got %h %b %0d exp 204 1 1", rdd, m_rw, m_rda);
    end
    total++;
    if (dout !== prev) begin
      bad++; $display("FAIL jal_hold got %h exp %h", dout, prev);
    end
    step();
    clr();
    total++;
    if (rdd !== 32'h999) begin
      bad++; $display("FAIL alu_pipe got %h exp 999", rdd);
    end
  endtask

  task automatic test_reset_busy();
    mr = 1; m2r = 1; rw = 1; rda = 5'd3;
    f3 = 3'b010; alu = 32'h200; dmo = 32'h5555_5555;
    step();
    step();
    #2;
    total++;
    if (req !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL rb_busy got %b/%b exp 1/1", req, stall);
    end
    rst = 1;
    clr();
    step();
    rst = 0;
    rdy = 1;
    dmo = 32'h5555_5555;
    #2;
    total++;
    if (req !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL rb_idle got %b/%b exp 0/0", req, stall);
    end
    total++;
    if ({rdd, dout, m_rda, m_rw, m_m2r} !== '0) begin
      bad++; $display("FAIL rb_regs got %h %h %0d %b %b exp 0", rdd, dout, m_rda, m_rw, m_m2r);
    end
    step();
    total++;
    if (dout !== 32'h0 || m_rw !== 1'b0) begin
      bad++; $display("FAIL rb_late got %h %b exp 0 0", dout, m_rw);
    end
    clr();
  endtask

  task automatic test_xlen64();
    w_mw = 1; w_f3 = 3'b011; w_alu = 64'h1008;
    w_rs2 = 64'h1122_3344_5566_7788; w_rdy = 1;
    #2;
    total++;
    if (w_web !== 8'h00 || w_req !== 1'b1) begin
      bad++; $display("FAIL sd_web got %h/%b exp 00/1", w_web, w_req);
    end
    total++;
    if (w_din !== 64'h1122_3344_5566_7788 || w_addr !== 32'h1008) begin
      bad++; $display("FAIL sd_data got %h @%h exp 1122334455667788 @1008", w_din, w_addr);
    end
    step();
    clr();
    w_mr = 1; w_f3 = 3'b010; w_alu = 64'h1004;
    w_dmo = 64'h8000_0000_0000_0000; w_rdy = 1;
    #2;
    total++;
    if (w_addr !== 32'h1000 || w_stall !== 1'b0) begin
      bad++; $display("FAIL lw64_addr got %h/%b exp 1000/0", w_addr, w_stall);
    end
    step();
    w_f3 = 3'b110;
    #2;
    total++;
    if (w_dout !== 64'hFFFF_FFFF_8000_0000) begin
      bad++; $display("FAIL lw64_dout got %h exp ffffffff80000000", w_dout);
    end
    step();
    clr();
    total++;
    if (w_dout !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL lwu64_dout got %h exp 0000000080000000", w_dout);
    end
    w_mr = 1; w_f3 = 3'b011; w_alu = 64'h1004;
    #2;
    total++;
    if (w_req !== 1'b0 || w_stall !== 1'b0) begin
      bad++; $display("FAIL ld64_mis got %b/%b exp 0/0", w_req, w_stall);
    end
    step();
    clr();
    total++;
    if (w_mis !== 1'b1 || w_rw !== 1'b0) begin
      bad++; $display("FAIL ld64_flag got %b/%b exp 1/0", w_mis, w_rw);
    end
  endtask

  initial begin
    rst = 1;
    clr();
    test_reset();
    test_store("sb", 3'b000, 32'h103, 32'h0000_00AB, 4'b0111, 32'hAB00_0000);
    test_store("sh", 3'b001, 32'h102, 32'h0000_1234, 4'b0011, 32'h1234_0000);
    test_store("sw", 3'b010, 32'h100, 32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF);
    test_load("lb", 3'b000, 32'h102, 32'h0080_0000, 3, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h102, 32'h0080_0000, 3, 32'h0000_0080);
    test_load("lw", 3'b010, 32'h100, 32'h1234_5678, 0, 32'h1234_5678);
    test_load("lhu", 3'b101, 32'h102, 32'hABCD_0000, 0, 32'h0000_ABCD);
    test_load("lh", 3'b001, 32'h100, 32'h0000_8001, 1, 32'hFFFF_8001);
    test_misalign("lh_mis", 3'b001, 32'h101, 1'b0);
    test_misalign("sw_mis", 3'b010, 32'h102, 1'b1);
    test_jal();
    test_reset_busy();
    test_xlen64();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
